// File: rtl/risc16_pkg.sv
// Shared widths and defaults for the risc16 front end.
package risc16_pkg;

  // Program counter / instruction memory address width.
  localparam int PC_W    = 4;
  // Instruction word width.
  localparam int INSTR_W = 16;
  // Default fetch queue depth (power of two, 2..8).
  localparam int DEPTH   = 4;

  // Pointer width for a power-of-two queue depth.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Pointer width for the default depth.
  localparam int PTR_W = ptr_w(DEPTH);

endpackage

// File: rtl/fetch_queue_fifo.sv
// Fetch queue storage: entry array, head/tail pointers and occupancy.
// flush empties the queue on the next edge and wins over push/pop.
module fetch_queue_fifo
  import risc16_pkg::ptr_w;
#(
  parameter int W     = 20,
  parameter int DEPTH = 4,
  localparam int PW   = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [PW:0]   count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;

  // Next-state pointers and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; left uninitialised since empty entries are never shown.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[tail_q] <= wdata;
  end

  // Head output is forced to zero while empty so reset shows clean outputs.
  assign rdata = (count_q != '0) ? mem_q[head_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: sequential fetch from a combinational
// instruction memory into a small FIFO feeding the decoder, with
// redirect flush from execute.
module instr_fetch_queue
  import risc16_pkg::ptr_w;
#(
  parameter int PC_W    = risc16_pkg::PC_W,
  parameter int INSTR_W = risc16_pkg::INSTR_W,
  parameter int DEPTH   = risc16_pkg::DEPTH,
  localparam int PW     = ptr_w(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [PC_W-1:0]    dec_pc,
  output logic [PW:0]        count
);

  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [PC_W-1:0]         fetch_pc_q, fetch_pc_d;
  logic                    push, pop;
  logic [INSTR_W+PC_W-1:0] head_entry;

  assign imem_addr = fetch_pc_q;
  assign dec_valid = (count != '0);

  // A redirect kills both the decoder handshake and the fetch that cycle.
  assign pop  = dec_valid & dec_ready & ~redirect;
  assign push = fetch_en & ~redirect & ((count < FULL_CNT) | pop);

  // Fetch address: jump target on redirect, otherwise advance per push.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect)  fetch_pc_d = redirect_pc;
    else if (push) fetch_pc_d = fetch_pc_q + 1'b1;
  end

  // Fetch address register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fetch_pc_q <= '0;
    else     fetch_pc_q <= fetch_pc_d;
  end

  fetch_queue_fifo #(
    .W     (INSTR_W + PC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (push),
    .pop   (pop),
    .wdata ({imem_data, fetch_pc_q}),
    .rdata (head_entry),
    .count (count)
  );

  assign dec_instr = head_entry[PC_W +: INSTR_W];
  assign dec_pc    = head_entry[PC_W-1:0];

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a combinational memory
// returning 16'hA000 + address.
module tb_instr_fetch_queue;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic [3:0]  imem_addr;
  logic [15:0] imem_data;
  logic        redirect;
  logic [3:0]  redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [15:0] dec_instr;
  logic [3:0]  dec_pc;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  instr_fetch_queue dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_en    (fetch_en),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_instr   (dec_instr),
    .dec_pc      (dec_pc),
    .count       (count)
  );

  assign imem_data = 16'hA000 + {12'h000, imem_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
      $error("check %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b0; dec_ready = 1'b0; redirect = 1'b0; redirect_pc = 4'd0;
    #3;
    chk("rst_valid", 32'(dec_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_pc", 32'(dec_pc), 32'd0);
    chk("rst_instr", 32'(dec_instr), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    tick();
    rst = 1'b0;

    // fetch disabled: fetch_pc holds, nothing enters the queue
    tick();
    chk("hold_addr", 32'(imem_addr), 32'd0);
    chk("hold_count", 32'(count), 32'd0);

    // streaming with decoder always ready
    fetch_en = 1'b1; dec_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stream_instr", 32'(dec_instr), 32'hA000 + i);
      chk("stream_pc", 32'(dec_pc), 32'(i));
      chk("stream_count", 32'(count), 32'd1);
    end

    // back-pressure fills the queue
    rst = 1'b1; #2; rst = 1'b0;
    dec_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("fill_count", 32'(count), (i < 3) ? 32'(i + 1) : 32'd4);
      chk("fill_head", 32'(dec_instr), 32'hA000);
    end
    chk("fill_addr", 32'(imem_addr), 32'd4);

    // full queue drains and refills at one instruction per cycle
    dec_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("full_instr", 32'(dec_instr), 32'hA000 + i);
      chk("full_count", 32'(count), 32'd4);
    end
    chk("full_addr", 32'(imem_addr), 32'd9);

    // pop only with fetch disabled
    fetch_en = 1'b0;
    tick();
    chk("drain_count", 32'(count), 32'd3);
    chk("drain_instr", 32'(dec_instr), 32'hA006);
    chk("drain_addr", 32'(imem_addr), 32'd9);

    // redirect to 9 with decoder ready
    redirect = 1'b1; redirect_pc = 4'd9; fetch_en = 1'b1; dec_ready = 1'b1;
    tick();
    chk("redir_count", 32'(count), 32'd0);
    chk("redir_valid", 32'(dec_valid), 32'd0);
    chk("redir_addr", 32'(imem_addr), 32'd9);
    redirect = 1'b0; redirect_pc = 4'd3;
    tick();
    chk("redir_pc", 32'(dec_pc), 32'd9);
    chk("redir_instr", 32'(dec_instr), 32'hA009);
    chk("redir_count1", 32'(count), 32'd1);
    tick();
    chk("redir_next_pc", 32'(dec_pc), 32'd10);

    // redirect to 14, then free-run across the address wrap
    redirect = 1'b1; redirect_pc = 4'd14;
    tick();
    chk("wrap_flush", 32'(count), 32'd0);
    redirect = 1'b0; redirect_pc = 4'd5;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wrap_pc", 32'(dec_pc), 32'((14 + i) % 16));
      chk("wrap_instr", 32'(dec_instr), 32'hA000 + ((14 + i) % 16));
      chk("wrap_count", 32'(count), 32'd1);
    end

    // reset mid-cycle with two entries queued
    dec_ready = 1'b0;
    tick();
    chk("pre_rst_count", 32'(count), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(dec_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_pc", 32'(dec_pc), 32'd0);
    chk("arst_instr", 32'(dec_instr), 32'd0);
    chk("arst_addr", 32'(imem_addr), 32'd0);
    rst = 1'b0; dec_ready = 1'b1;
    tick();
    chk("post_rst_pc", 32'(dec_pc), 32'd0);
    chk("post_rst_instr", 32'(dec_instr), 32'hA000);
    chk("post_rst_count", 32'(count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
